// File: rtl/ro_sensor_scheduler_pkg.sv
// Shared types for the ring-oscillator aging sensor scheduler.
// Holds the FSM encoding, the result tag and the channel search helper.
package ro_sensor_pkg;

    localparam int CH_W   = 4;
    localparam int MAX_RO = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_REPORT
    } ro_state_e;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic            sat;
    } ro_tag_t;

    // Lowest set bit of m at index >= from; msb of the result is "found".
    function automatic logic [CH_W:0] find_ch(
        input logic [MAX_RO-1:0] m,
        input logic [CH_W:0]     from
    );
        logic [CH_W:0] r;
        r = '0;
        for (int i = MAX_RO - 1; i >= 0; i--) begin
            if (m[i] && ((CH_W+1)'(i) >= from)) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ro_sensor_scheduler_if.sv
// Result record stream of the sensor scheduler (valid/ready handshake).
// The scheduler is the master; the register/readout logic is the slave.
interface ro_sensor_scheduler_if
    import ro_sensor_pkg::*;
#(
    parameter int CNT_W = 20
);

    logic             res_valid;
    logic             res_ready;
    logic [CH_W-1:0]  res_ch;
    logic [CNT_W-1:0] res_count;
    logic             res_sat;

    modport master (
        output res_valid,
        output res_ch,
        output res_count,
        output res_sat,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_ch,
        input  res_count,
        input  res_sat,
        output res_ready
    );

endinterface

// File: rtl/ro_sensor_scheduler_edge_counter.sv
// Synchronizer, rising-edge detector and saturating counter for the
// currently selected oscillator output.
module ro_edge_counter #(
    parameter int CNT_W = 20
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             ro_in,
    input  logic             clear,
    input  logic             gate_en,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    // sync[0], sync[1] form the synchronizer; sync[2] is the edge history.
    logic [2:0] sync;
    logic       rise;

    assign rise = sync[1] & ~sync[2];
    assign sat  = &count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync  <= '0;
            count <= '0;
        end else if (clear) begin
            sync  <= '0;
            count <= '0;
        end else begin
            sync <= {sync[1:0], ro_in};
            if (gate_en && rise && !sat) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_sensor_scheduler.sv
// Sweeps enabled ring oscillators one at a time: settle, count edges over a
// gate window, then hand the count out as a channel-tagged record.
module ro_sensor_scheduler
    import ro_sensor_pkg::*;
#(
    parameter int NUM_RO = 4,
    parameter int CNT_W  = 20,
    parameter int GATE_W = 24
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [NUM_RO-1:0] ch_mask,
    input  logic [GATE_W-1:0] settle_cycles,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic [NUM_RO-1:0] ro_en,
    input  logic [NUM_RO-1:0] ro_clk,
    output logic              busy,
    output logic              done,
    ro_sensor_scheduler_if.master res
);

    ro_state_e         state;
    logic [CH_W-1:0]   ch;
    logic [NUM_RO-1:0] mask_q;
    logic              cont_q;
    logic [GATE_W-1:0] settle_q;
    logic [GATE_W-1:0] gate_q;
    logic [GATE_W-1:0] timer;
    logic [GATE_W-1:0] gate_eff;

    logic              valid_q;
    ro_tag_t           tag_q;
    logic [CNT_W-1:0]  count_q;

    logic [MAX_RO-1:0] mask_pad;
    logic [MAX_RO-1:0] new_pad;
    logic [MAX_RO-1:0] ro_pad;
    logic [CH_W:0]     first_new;
    logic [CH_W:0]     first_q;
    logic [CH_W:0]     next_q;
    logic [CH_W-1:0]   wrap_ch;
    logic              more;

    logic              ro_sel;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_sat;

    function automatic logic [NUM_RO-1:0] onehot(input logic [CH_W-1:0] c);
        return NUM_RO'(1) << c;
    endfunction

    always_comb begin
        mask_pad = '0;
        new_pad  = '0;
        ro_pad   = '0;
        mask_pad[NUM_RO-1:0] = mask_q;
        new_pad[NUM_RO-1:0]  = ch_mask;
        ro_pad[NUM_RO-1:0]   = ro_clk;
        ro_sel    = ro_pad[ch];
        first_new = find_ch(new_pad, '0);
        first_q   = find_ch(mask_pad, '0);
        next_q    = find_ch(mask_pad, (CH_W+1)'(ch) + (CH_W+1)'(1));
        wrap_ch   = next_q[CH_W] ? next_q[CH_W-1:0] : first_q[CH_W-1:0];
        more      = next_q[CH_W] | cont_q;
        gate_eff  = (gate_q == '0) ? GATE_W'(1) : gate_q;
    end

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .aclk    (aclk),
        .aresetn (aresetn),
        .ro_in   (ro_sel),
        .clear   (state != ST_MEASURE),
        .gate_en (state == ST_MEASURE),
        .count   (cnt),
        .sat     (cnt_sat)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            ch       <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            settle_q <= '0;
            gate_q   <= '0;
            timer    <= '0;
            ro_en    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            count_q  <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= ST_IDLE;
                ro_en   <= '0;
                busy    <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start && |ch_mask) begin
                            mask_q   <= ch_mask;
                            cont_q   <= continuous;
                            settle_q <= settle_cycles;
                            gate_q   <= gate_cycles;
                            ch       <= first_new[CH_W-1:0];
                            ro_en    <= onehot(first_new[CH_W-1:0]);
                            busy     <= 1'b1;
                            timer    <= settle_cycles;
                            state    <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (timer <= GATE_W'(1)) begin
                            timer <= gate_eff;
                            state <= ST_MEASURE;
                        end else begin
                            timer <= timer - GATE_W'(1);
                        end
                    end
                    ST_MEASURE: begin
                        if (timer <= GATE_W'(1)) begin
                            ro_en   <= '0;
                            valid_q <= 1'b1;
                            tag_q   <= '{ch: ch, sat: cnt_sat};
                            count_q <= cnt;
                            state   <= ST_REPORT;
                        end else begin
                            timer <= timer - GATE_W'(1);
                        end
                    end
                    ST_REPORT: begin
                        if (res.res_ready) begin
                            valid_q <= 1'b0;
                            if (more) begin
                                ch    <= wrap_ch;
                                ro_en <= onehot(wrap_ch);
                                timer <= settle_q;
                                state <= ST_SETTLE;
                            end else begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign res.res_valid = valid_q;
    assign res.res_ch    = tag_q.ch;
    assign res.res_sat   = tag_q.sat;
    assign res.res_count = count_q;

endmodule

// File: tb/tb_ro_sensor_scheduler.sv
// Bench for ro_sensor_scheduler: sweep table, backpressure, saturation,
// continuous/stop, corner inputs and asynchronous reset.
module tb_ro_sensor_scheduler;
    import ro_sensor_pkg::*;

    logic        aclk = 0;
    logic        aresetn = 0;
    logic        start = 0;
    logic        start_s = 0;
    logic        stop = 0;
    logic        continuous = 0;
    logic [3:0]  ch_mask = 0;
    logic [23:0] settle_cycles = 0;
    logic [23:0] gate_cycles = 0;
    logic [3:0]  ro_en, ro_en_s;
    logic [3:0]  ro_clk;
    logic        busy, done, busy_s, done_s;
    logic        ro0 = 0, ro1 = 0, ro2 = 0, ro3 = 0;

    ro_sensor_scheduler_if #(.CNT_W(20)) res ();
    ro_sensor_scheduler_if #(.CNT_W(4))  res_s ();

    assign ro_clk = {ro3, ro2, ro1, ro0};

    ro_sensor_scheduler #(.NUM_RO(4), .CNT_W(20), .GATE_W(24)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
        .continuous(continuous), .ch_mask(ch_mask),
        .settle_cycles(settle_cycles), .gate_cycles(gate_cycles),
        .ro_en(ro_en), .ro_clk(ro_clk), .busy(busy), .done(done),
        .res(res.master)
    );

    ro_sensor_scheduler #(.NUM_RO(4), .CNT_W(4), .GATE_W(24)) u_sat (
        .aclk(aclk), .aresetn(aresetn), .start(start_s), .stop(stop),
        .continuous(1'b0), .ch_mask(ch_mask),
        .settle_cycles(settle_cycles), .gate_cycles(gate_cycles),
        .ro_en(ro_en_s), .ro_clk(ro_clk), .busy(busy_s), .done(done_s),
        .res(res_s.master)
    );

    always #5 aclk = ~aclk;
    // Oscillator periods 40/60/80/120 ns, phases kept off the aclk edges.
    initial begin #3; forever #20 ro0 = ~ro0; end
    initial begin #7; forever #30 ro1 = ~ro1; end
    initial begin #2; forever #40 ro2 = ~ro2; end
    initial begin #8; forever #60 ro3 = ~ro3; end

    typedef struct {
        logic [3:0] ch;
        int         count;
        logic       sat;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         settle;
        int         gate;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_d;
    int   vecs = 0;
    int   errs = 0;
    int   done_cnt = 0;
    bit   multihot = 0;
    int   period_ns[4] = '{40, 60, 80, 120};
    vec_t tbl[5];

    always @(negedge aclk) begin
        if ($countones(ro_en) > 1) multihot = 1;
        if (done) done_cnt++;
        if (aresetn && res.res_valid && res.res_ready) begin
            vecs++;
            if (sb.size() == 0) begin
                errs++;
                $display("FAIL unexpected_record: got ch=%0d count=%0d required none",
                         res.res_ch, res.res_count);
            end else begin
                mon_e = sb.pop_front();
                mon_d = int'(res.res_count) - mon_e.count;
                if (res.res_ch !== mon_e.ch || res.res_sat !== mon_e.sat ||
                    mon_d > 1 || mon_d < -1) begin
                    errs++;
                    $display("FAIL record: got ch=%0d count=%0d sat=%0d required ch=%0d count=%0d+-1 sat=%0d",
                             res.res_ch, res.res_count, res.res_sat,
                             mon_e.ch, mon_e.count, mon_e.sat);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        vecs++;
        if (got != req) begin
            errs++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic pulse_start();
        @(posedge aclk); #1 start = 1;
        @(posedge aclk); #1 start = 0;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        int i;
        i = 0;
        while (busy && i < maxc) begin
            @(posedge aclk); #1;
            i++;
        end
        ok = !busy;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        int i;
        i = 0;
        while (!res.res_valid && i < maxc) begin
            @(posedge aclk); #1;
            i++;
        end
        ok = res.res_valid;
    endtask

    function automatic int exp_cnt(input int gate, input int c);
        return ((gate == 0) ? 1 : gate) * 10 / period_ns[c];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hi, d0;
        logic [19:0] cap_cnt;
        logic cap_sat;
        bit stable;

        tbl[0] = '{4'b0101, 16, 1000};
        tbl[1] = '{4'b1111, 4, 300};
        tbl[2] = '{4'b1000, 1, 50};
        tbl[3] = '{4'b1010, 8, 120};
        tbl[4] = '{4'b0110, 0, 7};
        res.res_ready = 1;
        res_s.res_ready = 1;

        repeat (3) @(posedge aclk);
        #1;
        check("reset_outs", {ro_en, busy, done, res.res_valid, res.res_sat}, 0);
        check("reset_cnt", res.res_count, 0);
        check("reset_ch", res.res_ch, 0);
        aresetn = 1;

        for (int r = 0; r < 5; r++) begin
            ch_mask = tbl[r].mask;
            settle_cycles = 24'(tbl[r].settle);
            gate_cycles = 24'(tbl[r].gate);
            continuous = 0;
            res.res_ready = 1;
            for (int c = 0; c < 4; c++)
                if (tbl[r].mask[c])
                    sb.push_back('{4'(c), exp_cnt(tbl[r].gate, c), 1'b0});
            d0 = done_cnt;
            pulse_start();
            wait_idle(20000, ok);
            check($sformatf("row%0d_idle", r), ok, 1);
            @(negedge aclk); #1;
            check($sformatf("row%0d_done", r), done_cnt - d0, 1);
            check($sformatf("row%0d_drained", r), sb.size(), 0);
        end

        // Latency and backpressure
        ch_mask = 4'b0101; settle_cycles = 3; gate_cycles = 10;
        res.res_ready = 0;
        pulse_start();
        check("start_en", ro_en, 1);
        check("start_busy", busy, 1);
        hi = 0;
        while (ro_en != 0 && hi < 100) begin
            hi++;
            @(posedge aclk); #1;
        end
        check("en_cycles", hi, 13);
        check("valid_rise", res.res_valid, 1);
        check("rep_ch", res.res_ch, 0);
        cap_cnt = res.res_count;
        cap_sat = res.res_sat;
        stable = 1;
        repeat (50) begin
            @(posedge aclk); #1;
            if (!res.res_valid || res.res_ch != 0 || res.res_count != cap_cnt ||
                res.res_sat != cap_sat || ro_en != 0 || !busy)
                stable = 0;
        end
        check("bp_stable", stable, 1);
        sb.push_back('{4'd0, exp_cnt(10, 0), 1'b0});
        sb.push_back('{4'd2, exp_cnt(10, 2), 1'b0});
        res.res_ready = 1;
        @(posedge aclk); #1;
        check("next_en", ro_en, 4'b0100);
        check("valid_drop", res.res_valid, 0);
        wait_valid(100, ok);
        check("ch2_valid", ok, 1);
        @(posedge aclk); #1;
        check("done_at_m1", done, 1);
        check("busy_at_m1", busy, 0);

        // Corner inputs
        ch_mask = 0;
        pulse_start();
        repeat (3) @(posedge aclk);
        #1;
        check("mask0_busy", busy, 0);
        check("mask0_en", ro_en, 0);
        ch_mask = 4'b0001;
        @(posedge aclk); #1 start = 1; stop = 1;
        @(posedge aclk); #1 start = 0; stop = 0;
        check("stop_over_start", busy, 0);
        ch_mask = 4'b0010; settle_cycles = 0; gate_cycles = 0;
        sb.push_back('{4'd1, 0, 1'b0});
        pulse_start();
        check("s0_en", ro_en, 4'b0010);
        hi = 0;
        while (ro_en != 0 && hi < 100) begin
            hi++;
            @(posedge aclk); #1;
        end
        check("s0g0_cycles", hi, 2);
        wait_idle(100, ok);
        check("s0g0_idle", ok, 1);

        // Saturation on the narrow-counter instance
        ch_mask = 4'b0001; settle_cycles = 16; gate_cycles = 200;
        @(posedge aclk); #1 start_s = 1;
        @(posedge aclk); #1 start_s = 0;
        hi = 0;
        while (!res_s.res_valid && hi < 1000) begin
            hi++;
            @(posedge aclk); #1;
        end
        check("sat_valid", res_s.res_valid, 1);
        check("sat_count", res_s.res_count, 15);
        check("sat_flag", res_s.res_sat, 1);
        repeat (5) @(posedge aclk);

        // Continuous sweep, then stop mid-MEASURE
        ch_mask = 4'b1000; settle_cycles = 2; gate_cycles = 100;
        continuous = 1;
        res.res_ready = 1;
        for (int k = 0; k < 3; k++) sb.push_back('{4'd3, exp_cnt(100, 3), 1'b0});
        d0 = done_cnt;
        pulse_start();
        continuous = 0;
        hi = 0;
        while (sb.size() > 0 && hi < 2000) begin
            hi++;
            @(posedge aclk); #1;
        end
        check("cont_drained", sb.size(), 0);
        check("cont_busy", busy, 1);
        repeat (6) @(posedge aclk);
        #1 stop = 1;
        @(posedge aclk); #1 stop = 0;
        check("stop_outs", {ro_en, busy, res.res_valid}, 0);
        repeat (150) @(posedge aclk);
        #1;
        check("cont_no_done", done_cnt - d0, 0);
        check("stop_idle", busy, 0);

        // Asynchronous reset while a record is pending
        ch_mask = 4'b0001; settle_cycles = 1; gate_cycles = 20;
        res.res_ready = 0;
        pulse_start();
        wait_valid(100, ok);
        check("rst_pre_valid", ok, 1);
        #3 aresetn = 0;
        #1;
        check("rst_outs", {ro_en, busy, done, res.res_valid, res.res_sat}, 0);
        check("rst_cnt", res.res_count, 0);
        @(negedge aclk);
        aresetn = 1;
        res.res_ready = 1;
        repeat (20) @(posedge aclk);
        #1;
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", res.res_valid, 0);

        check("no_multihot", multihot, 0);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
